// File: rtl/mem_line_responder.sv
// Memory-side responder: p_num_lines x 128-bit line store serving one memreq at a time.
// Latency: memresp_val rises p_latency+1 cycles after the accept edge; array op done at accept.
// Backpressure: response held stable until memresp_rdy; memreq_rdy low from accept to handshake.
module mem_line_responder #(
    parameter int p_num_lines = 64,
    parameter int p_latency   = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         memreq_val,
    output logic         memreq_rdy,
    input  logic [2:0]   memreq_type,
    input  logic [7:0]   memreq_opaque,
    input  logic [31:0]  memreq_addr,
    input  logic [3:0]   memreq_len,
    input  logic [127:0] memreq_data,
    output logic         memresp_val,
    input  logic         memresp_rdy,
    output logic [2:0]   memresp_type,
    output logic [7:0]   memresp_opaque,
    output logic [1:0]   memresp_test,
    output logic [3:0]   memresp_len,
    output logic [127:0] memresp_data
);
    localparam int IW = $clog2(p_num_lines);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic           req_rdy_q, req_rdy_d;
    logic           resp_val_q, resp_val_d;
    logic [2:0]     resp_type_q, resp_type_d;
    logic [7:0]     resp_opaque_q, resp_opaque_d;
    logic [1:0]     resp_test_q, resp_test_d;
    logic [3:0]     resp_len_q, resp_len_d;
    logic [127:0]   resp_data_q, resp_data_d;

    // Line storage; deliberately has no reset so contents survive a reset pulse.
    logic [127:0]   mem [p_num_lines];

    logic [IW-1:0]  idx;
    logic [1:0]     word;
    logic [6:0]     word_lsb;
    logic [127:0]   cur_line;
    logic [127:0]   wr_line;
    logic [127:0]   rd_data;
    logic           type_ok;
    logic           len_ok;
    logic           align_ok;
    logic           req_err;
    logic           is_write;
    logic           accept;
    logic           mem_we;
    logic           unused_addr_hi;

    // Address bits above the line index wrap, so they are intentionally dropped.
    assign unused_addr_hi = ^memreq_addr[31:4+IW];

    // Decode the incoming request and precompute both the read result and the merged write line.
    always_comb begin
        idx      = memreq_addr[4+IW-1:4];
        word     = memreq_addr[3:2];
        word_lsb = {word, 5'd0};
        cur_line = mem[idx];

        type_ok  = (memreq_type <= 3'd2);
        len_ok   = (memreq_len == 4'd0) || (memreq_len == 4'd4);
        align_ok = (memreq_len == 4'd0) ? (memreq_addr[3:0] == 4'd0)
                                        : (memreq_addr[1:0] == 2'd0);
        req_err  = !(type_ok && len_ok && align_ok);
        is_write = (memreq_type == 3'd1) || (memreq_type == 3'd2);

        // Reset gates the accept so a request presented during reset never touches the array.
        accept   = memreq_val && req_rdy_q && reset;
        mem_we   = accept && !req_err && is_write;

        wr_line  = cur_line;
        if (memreq_len == 4'd0) begin
            wr_line = memreq_data;
        end else begin
            wr_line[word_lsb +: 32] = memreq_data[31:0];
        end

        rd_data = 128'd0;
        if (!req_err && !is_write) begin
            if (memreq_len == 4'd0) begin
                rd_data = cur_line;
            end else begin
                rd_data[31:0] = cur_line[word_lsb +: 32];
            end
        end
    end

    // Next-state logic for the IDLE -> WAIT -> RESP sequence and the response registers.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        req_rdy_d     = req_rdy_q;
        resp_val_d    = resp_val_q;
        resp_type_d   = resp_type_q;
        resp_opaque_d = resp_opaque_q;
        resp_test_d   = resp_test_q;
        resp_len_d    = resp_len_q;
        resp_data_d   = resp_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    resp_type_d   = memreq_type;
                    resp_opaque_d = memreq_opaque;
                    resp_len_d    = memreq_len;
                    resp_test_d   = req_err ? 2'd1 : 2'd0;
                    resp_data_d   = rd_data;
                    cnt_d         = 4'(p_latency);
                    req_rdy_d     = 1'b0;
                    if (p_latency > 0) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d    = ST_RESP;
                        resp_val_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = ST_RESP;
                    resp_val_d = 1'b1;
                end
            end
            ST_RESP: begin
                if (memresp_rdy) begin
                    state_d    = ST_IDLE;
                    resp_val_d = 1'b0;
                    req_rdy_d  = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                resp_val_d = 1'b0;
                req_rdy_d  = 1'b1;
            end
        endcase
    end

    // Control and response registers; reset drops any in-flight request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 4'd0;
            req_rdy_q     <= 1'b1;
            resp_val_q    <= 1'b0;
            resp_type_q   <= 3'd0;
            resp_opaque_q <= 8'd0;
            resp_test_q   <= 2'd0;
            resp_len_q    <= 4'd0;
            resp_data_q   <= 128'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_rdy_q     <= req_rdy_d;
            resp_val_q    <= resp_val_d;
            resp_type_q   <= resp_type_d;
            resp_opaque_q <= resp_opaque_d;
            resp_test_q   <= resp_test_d;
            resp_len_q    <= resp_len_d;
            resp_data_q   <= resp_data_d;
        end
    end

    // Array write lands on the accept edge so a following read sees the new data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wr_line;
        end
    end

    assign memreq_rdy     = req_rdy_q;
    assign memresp_val    = resp_val_q;
    assign memresp_type   = resp_type_q;
    assign memresp_opaque = resp_opaque_q;
    assign memresp_test   = resp_test_q;
    assign memresp_len    = resp_len_q;
    assign memresp_data   = resp_data_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Bench for mem_line_responder: default-latency and zero-latency instances vs a line-array model.
// Latency: checks response timing cycle by cycle against p_latency+1.
// Backpressure: holds memresp_rdy low for several cycles and checks stability.
module tb_mem_line_responder;
    localparam int LINES = 64;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         val_a = 1'b0;
    logic         val_b = 1'b0;
    logic         resp_rdy = 1'b1;
    logic [2:0]   req_type = 3'd0;
    logic [7:0]   req_opaque = 8'd0;
    logic [31:0]  req_addr = 32'd0;
    logic [3:0]   req_len = 4'd0;
    logic [127:0] req_data = 128'd0;

    logic         rdy_a, rval_a, rdy_b, rval_b;
    logic [2:0]   rtype_a, rtype_b;
    logic [7:0]   ropq_a, ropq_b;
    logic [1:0]   rtest_a, rtest_b;
    logic [3:0]   rlen_a, rlen_b;
    logic [127:0] rdata_a, rdata_b;

    // Packed view: {req_rdy, resp_val, type, opaque, test, len, data}
    logic [146:0] out_a, out_b;
    assign out_a = {rdy_a, rval_a, rtype_a, ropq_a, rtest_a, rlen_a, rdata_a};
    assign out_b = {rdy_b, rval_b, rtype_b, ropq_b, rtest_b, rlen_b, rdata_b};

    int vectors = 0;
    int miscompares = 0;

    logic [127:0] mdl_a [LINES];
    logic [127:0] mdl_b [LINES];

    always #5 clk = ~clk;

    mem_line_responder #(.p_num_lines(LINES), .p_latency(2)) dut (
        .clk(clk), .reset(reset),
        .memreq_val(val_a), .memreq_rdy(rdy_a),
        .memreq_type(req_type), .memreq_opaque(req_opaque), .memreq_addr(req_addr),
        .memreq_len(req_len), .memreq_data(req_data),
        .memresp_val(rval_a), .memresp_rdy(resp_rdy),
        .memresp_type(rtype_a), .memresp_opaque(ropq_a), .memresp_test(rtest_a),
        .memresp_len(rlen_a), .memresp_data(rdata_a)
    );

    mem_line_responder #(.p_num_lines(LINES), .p_latency(0)) dut0 (
        .clk(clk), .reset(reset),
        .memreq_val(val_b), .memreq_rdy(rdy_b),
        .memreq_type(req_type), .memreq_opaque(req_opaque), .memreq_addr(req_addr),
        .memreq_len(req_len), .memreq_data(req_data),
        .memresp_val(rval_b), .memresp_rdy(resp_rdy),
        .memresp_type(rtype_b), .memresp_opaque(ropq_b), .memresp_test(rtest_b),
        .memresp_len(rlen_b), .memresp_data(rdata_b)
    );

    function automatic logic [146:0] snap(input int w);
        return (w == 0) ? out_a : out_b;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: line array indexed by address modulo the storage size; returns expected data/error.
    task automatic model_op(input int w, input logic [2:0] t, input logic [31:0] addr,
                            input logic [3:0] len, input logic [127:0] d,
                            output logic [127:0] exp_d, output bit err);
        int idx, wd;
        bit wr;
        logic [127:0] line, mask;
        idx  = int'((addr >> 4) % LINES);
        wd   = int'((addr >> 2) % 4);
        err  = (t > 3'd2) || !(len == 4'd0 || len == 4'd4) ||
               (len == 4'd0 && (addr % 16) != 0) || (len == 4'd4 && (addr % 4) != 0);
        wr   = (t == 3'd1) || (t == 3'd2);
        line = (w == 0) ? mdl_a[idx] : mdl_b[idx];
        exp_d = 128'd0;
        if (!err && !wr) begin
            exp_d = (len == 4'd0) ? line : ((line >> (32 * wd)) & 128'hFFFF_FFFF);
        end
        if (!err && wr) begin
            if (len == 4'd0) begin
                line = d;
            end else begin
                mask = 128'hFFFF_FFFF;
                mask = mask << (32 * wd);
                line = (line & ~mask) | ((d & 128'hFFFF_FFFF) << (32 * wd));
            end
            if (w == 0) mdl_a[idx] = line;
            else        mdl_b[idx] = line;
        end
    endtask

    task automatic scramble_req();
        req_type   = 3'($urandom);
        req_opaque = 8'($urandom);
        req_addr   = $urandom;
        req_len    = 4'($urandom);
        req_data   = rand128();
    endtask

    // One complete transaction; call and return aligned to a negedge.
    task automatic txn(input int w, input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [3:0] len, input logic [127:0] d, input int stall);
        logic [127:0] exp_d;
        logic [146:0] o, first;
        bit err;
        int lat, n;
        lat = (w == 0) ? 2 : 0;
        model_op(w, t, addr, len, d, exp_d, err);
        o = snap(w);
        n = 0;
        while (!o[146] && n < 20) begin
            @(negedge clk);
            o = snap(w);
            n++;
        end
        chk("req_rdy_before_accept", o[146], 1);
        req_type = t; req_opaque = op; req_addr = addr; req_len = len; req_data = d;
        resp_rdy = (stall == 0);
        if (w == 0) val_a = 1'b1; else val_b = 1'b1;
        @(negedge clk);
        val_a = 1'b0; val_b = 1'b0;
        scramble_req();
        for (int k = 1; k <= lat; k++) begin
            o = snap(w);
            chk("resp_val_early", o[145], 0);
            chk("req_rdy_busy", o[146], 0);
            @(negedge clk);
        end
        o = snap(w);
        chk("resp_val_on_time", o[145], 1);
        chk("req_rdy_in_resp", o[146], 0);
        chk("resp_type", o[144:142], t);
        chk("resp_opaque", o[141:134], op);
        chk("resp_test", o[133:132], err ? 2'd1 : 2'd0);
        chk("resp_len", o[131:128], len);
        chk("resp_data", o[127:0], exp_d);
        first = o;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            o = snap(w);
            chk("resp_stable", o[145:0], first[145:0]);
            chk("req_rdy_stall", o[146], 0);
        end
        resp_rdy = 1'b1;
        @(negedge clk);
        o = snap(w);
        chk("resp_val_after_hs", o[145], 0);
        chk("req_rdy_after_hs", o[146], 1);
    endtask

    // Accept a request on the latency-2 instance, then pulse reset while it waits.
    task automatic txn_rst(input logic [2:0] t, input logic [31:0] addr, input logic [127:0] d);
        logic [127:0] exp_d;
        logic [146:0] o;
        bit err;
        model_op(0, t, addr, 4'd0, d, exp_d, err);
        req_type = t; req_opaque = 8'h5A; req_addr = addr; req_len = 4'd0; req_data = d;
        val_a = 1'b1;
        @(negedge clk);
        val_a = 1'b0;
        o = snap(0);
        chk("rst_pre_busy", o[146], 0);
        #2 reset = 1'b0;
        #1 o = snap(0);
        chk("rst_async_rdy", o[146], 1);
        chk("rst_async_val", o[145], 0);
        chk("rst_async_fields", o[144:0], 0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            o = snap(0);
            chk("rst_no_resp", o[145], 0);
            chk("rst_idle_rdy", o[146], 1);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [146:0] o;
        logic [127:0] saved;
        int w, r, stall;
        logic [2:0] t;
        logic [3:0] len;
        logic [31:0] addr;

        // Reset state of both instances
        repeat (2) @(negedge clk);
        o = snap(0);
        chk("reset_a_rdy", o[146], 1);
        chk("reset_a_resp", o[145:0], 0);
        o = snap(1);
        chk("reset_b_rdy", o[146], 1);
        chk("reset_b_resp", o[145:0], 0);
        reset = 1'b1;
        @(negedge clk);

        // Fill every line of both instances using init requests
        for (int i = 0; i < LINES; i++) begin
            txn(0, 3'd2, 8'(i), 32'(i * 16), 4'd0, rand128(), 0);
            txn(1, 3'd2, 8'(i), 32'(i * 16), 4'd0, rand128(), 0);
        end

        // Line write then read back at default latency
        txn(0, 3'd1, 8'h11, 32'h0000_0100, 4'd0, 128'h0123456789ABCDEF0123456789ABCDEF, 0);
        txn(0, 3'd0, 8'h12, 32'h0000_0100, 4'd0, 128'd0, 0);

        // Word write into a zeroed line, then full-line read
        txn(0, 3'd1, 8'h20, 32'h0000_0100, 4'd0, 128'd0, 0);
        txn(0, 3'd1, 8'h21, 32'h0000_0108, 4'd4, 128'hDEADBEEF, 0);
        txn(0, 3'd0, 8'h22, 32'h0000_0100, 4'd0, 128'd0, 0);

        // Response backpressure for 5 cycles
        txn(0, 3'd0, 8'h30, 32'h0000_0100, 4'd0, 128'd0, 5);

        // Wrap-around on the zero-latency instance
        txn(1, 3'd1, 8'h40, 32'h0000_0000, 4'd0, rand128(), 0);
        txn(1, 3'd0, 8'h41, 32'h0000_0400, 4'd0, 128'd0, 0);

        // Error cases leave the line untouched
        txn(0, 3'd5, 8'h50, 32'h0000_0100, 4'd0, rand128(), 0);
        txn(0, 3'd1, 8'h51, 32'h0000_0102, 4'd4, rand128(), 0);
        txn(0, 3'd1, 8'h52, 32'h0000_0104, 4'd0, rand128(), 0);
        txn(1, 3'd1, 8'h53, 32'h0000_0100, 4'd7, rand128(), 0);
        txn(0, 3'd0, 8'h54, 32'h0000_0100, 4'd0, 128'd0, 0);

        // Garbage on the request fields with val low is ignored
        for (int k = 0; k < 4; k++) begin
            scramble_req();
            @(negedge clk);
            o = snap(0);
            chk("idle_garbage_val", o[145], 0);
            chk("idle_garbage_rdy", o[146], 1);
        end

        // Reset during WAIT after a read: dropped, old data kept
        txn_rst(3'd0, 32'h0000_0100, 128'd0);
        txn(0, 3'd0, 8'h60, 32'h0000_0100, 4'd0, 128'd0, 0);
        // Reset during WAIT after a write: the accept-edge write stays
        saved = rand128();
        txn_rst(3'd1, 32'h0000_0230, saved);
        txn(0, 3'd0, 8'h61, 32'h0000_0230, 4'd0, 128'd0, 0);

        // Randomized traffic across both instances
        for (int i = 0; i < 150; i++) begin
            w = int'($urandom_range(0, 1));
            r = int'($urandom_range(0, 9));
            if (r <= 3 || r == 9) t = 3'd0;
            else if (r <= 6)      t = 3'd1;
            else if (r == 7)      t = 3'd2;
            else                  t = 3'($urandom_range(3, 7));
            r = int'($urandom_range(0, 7));
            if (r == 0)      len = 4'($urandom_range(0, 15));
            else if (r <= 3) len = 4'd4;
            else             len = 4'd0;
            addr = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                addr = (len == 4'd4) ? (addr & 32'hFFFF_FFFC) : (addr & 32'hFFFF_FFF0);
            end
            stall = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            txn(w, t, 8'($urandom), addr, len, rand128(), stall);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the blocking cache's memreq/memresp interface; it is the endpoint that services refill and evict traffic from the cache controller.
- Accepts one request at a time and holds storage for p_num_lines 128-bit cachelines.
- Answers each request after a configurable latency, and stalls its response until the cache accepts it.
- Used as the main-memory stand-in beneath the lab3 caches in unit and integration benches.

Parameters:
p_num_lines, 64, number of 16-byte lines stored (power of 2, ≥2)
p_latency, 2, extra wait cycles between request accept and response valid (0..15)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous active-low reset (asserted when 0)
memreq_val  in  1  request valid
memreq_rdy  out  1  request ready
memreq_type  in  3  0=read, 1=write, 2=init; 3..7 illegal
memreq_opaque  in  8  tag echoed in response
memreq_addr  in  32  byte address
memreq_len  in  4  0=16-byte line, 4=32-bit word; others illegal
memreq_data  in  128  write data (word in [31:0] when len=4)
memresp_val  out  1  response valid
memresp_rdy  in  1  response ready
memresp_type  out  3  echo of request type
memresp_opaque  out  8  echo of request opaque
memresp_test  out  2  0=ok, 1=error
memresp_len  out  4  echo of request len
memresp_data  out  128  read data; 0 for write/init/error

Behaviour:
- Index = memreq_addr[4+log2(p_num_lines)-1:4]. Higher address bits are ignored, so addresses wrap modulo p_num_lines*16.
- Reset (reset==0, asynchronous):
  - state=IDLE, memreq_rdy=1, memresp_val=0.
  - All memresp_* fields are cleared to 0, and the latency counter is cleared.
  - Storage contents are NOT reset and persist across reset.
- States:
  - IDLE:
    - memreq_rdy=1, memresp_val=0.
    - On memreq_val&&memreq_rdy at a clock edge:
      - latch type/opaque/len into the response registers;
      - perform the array operation at that same edge;
      - load counter=p_latency;
      - go to WAIT if p_latency>0, else go to RESP.
  - WAIT:
    - memreq_rdy=0, memresp_val=0.
    - Counter decrements each cycle; go to RESP in the cycle after the counter reaches 1.
    - Net effect: memresp_val rises exactly p_latency+1 cycles after the accept edge.
  - RESP:
    - memreq_rdy=0, memresp_val=1, and all memresp_* fields are held stable until memresp_rdy=1.
    - On handshake return to IDLE. The next request can be accepted no earlier than the following cycle.
- Array operation at accept:
  - Read len=0, addr[3:0]==0: resp data = full line.
  - Read len=4, addr[1:0]==0: resp data[31:0] = word addr[3:2] of the line; [127:32]=0.
  - Write/init len=0: the whole line is replaced by memreq_data.
  - Write/init len=4: only word addr[3:2] is replaced, with memreq_data[31:0]; the other words are unchanged.
  - Init is identical to write except that the response type is 2.
- Errors: illegal type, illegal len, or misaligned address (len=0 with addr[3:0]≠0, or len=4 with addr[1:0]≠0):
  - no array write;
  - memresp_test=1, memresp_data=0;
  - type/opaque/len are still echoed;
  - same latency as a legal request.
- Illegal values seen while memreq_val=0 are ignored.
- Response fields are registered. No combinational path exists from memresp_rdy or memreq_val to any output.
- memresp_rdy asserted while memresp_val=0 has no effect.
- memreq_val held high outside IDLE is not accepted; the request simply waits.
- Reset asserted mid-operation:
  - the pending request is dropped and no response is issued;
  - if reset occurs after the accept edge, the array write already done at that edge remains.
- Read-after-write to the same line returns the new data, because writes complete at the accept edge.

Test Plan:
- Line write then read, default latency: write addr 0x00000100 data 0x0123…CDEF (128b) opaque 0x11, then read the same line, memresp_rdy=1. Required:
  - write response: type=1, test=0, data=0, valid 3 cycles after accept;
  - read response: data = the written line, opaque echoed.
- Word write then line read: write len=4 addr 0x108 data 0xDEADBEEF over line 0x100 holding 0x0…0. Required: line read returns 0xDEADBEEF in bits [95:64], all other bits 0.
- Response backpressure: hold memresp_rdy=0 for 5 cycles after memresp_val rises. Required:
  - memresp_val and all fields stay stable;
  - memreq_rdy=0 throughout;
  - memreq_rdy returns to 1 the cycle after the handshake.
- Wrap-around and latency=0 (p_num_lines=64, p_latency=0): write line to addr 0x000, then read line at addr 0x400. Required: the read returns the 0x000 data with memresp_val 1 cycle after accept.
- Errors: a request with type=5 and a request with len=4 at addr 0x102. Required:
  - each returns test=1, data=0, type/opaque echoed;
  - a subsequent read shows the line unmodified.
- Reset mid-operation: drive reset=0 for 1 cycle while in WAIT after a read accept. Required:
  - memresp_val=0 and memreq_rdy=1 immediately (asynchronously);
  - no response for the dropped request;
  - a later read of a previously written line returns the old data.
